ks_sample_fifo: RTL and testbench

Avalon-MM slave sample buffer that feeds audio samples out at the rate set by the timer peripheral. The Nios II pushes Karplus-Strong output samples into an internal FIFO. Each rising edge of the timer's `toggle` output pops one sample onto a parallel DAC/PWM bus. Level, underflow and overflow status are reported, and an interrupt requests a refill when the FIFO runs low.

---
 rtl/ks_sample_fifo.sv | 144 ++++++++++++++
 tb/tb_ks_sample_fifo.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ks_sample_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | ks_sample_fifo: Avalon-MM sample FIFO popped by the timer toggle tick.     |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module ks_sample_fifo #(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        fifo_address,
  input  logic              fifo_chipselect,
  input  logic              fifo_write,
  input  logic [31:0]       fifo_writedata,
  output logic [31:0]       fifo_readdata,
  output logic              fifo_irq,
  input  logic              sample_tick,
  output logic [DATA_W-1:0] sample_out,
  output logic              sample_valid
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LVL_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] THR_RST  = (DEPTH_LOG2+1)'(DEPTH / 2);

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   level, level_nxt, threshold;
  logic                  underflow, overflow, irq_pending, enable, irq_en;
  logic                  sync1, sync2, sync3, tick;

  logic wr, push_req, stat_wr, ctrl_wr, thr_wr, flush;
  logic empty, full, pop, push, ovf_set, udf_set, irq_set;

  assign wr       = fifo_chipselect & fifo_write;
  assign push_req = wr & (fifo_address == 3'd0);
  assign stat_wr  = wr & (fifo_address == 3'd1);
  assign ctrl_wr  = wr & (fifo_address == 3'd2);
  assign thr_wr   = wr & (fifo_address == 3'd3);
  assign flush    = wr & (fifo_address == 3'd4);

  assign empty = (level == '0);
  assign full  = (level == LVL_FULL);

  // A flush in the same cycle as a tick suppresses both the pop and underflow.
  assign pop     = tick & enable & ~empty & ~flush;
  assign udf_set = tick & enable & empty & ~flush;
  // A slot freed by a same-cycle pop lets a write to a full FIFO through.
  assign push    = push_req & (~full | pop);
  assign ovf_set = push_req & full & ~pop;

  always_comb begin
    level_nxt = level;
    if (push && !pop)
      level_nxt = level + 1'b1;
    else if (pop && !push)
      level_nxt = level - 1'b1;
  end

  assign irq_set  = udf_set | (pop & (level_nxt <= threshold));
  assign fifo_irq = irq_pending & irq_en;

  // Three flops: two for metastability, the third to detect the rising edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
      tick  <= 1'b0;
    end else begin
      sync1 <= sample_tick;
      sync2 <= sync1;
      sync3 <= sync2;
      tick  <= sync2 & ~sync3;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= fifo_writedata[DATA_W-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= pop;
      if (pop)
        sample_out <= mem[rd_ptr];
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + 1'b1;
        if (pop)
          rd_ptr <= rd_ptr + 1'b1;
        level <= level_nxt;
      end
    end
  end

  // Sticky flags: set has priority over a coincident write-one-to-clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      underflow   <= 1'b0;
      overflow    <= 1'b0;
      irq_pending <= 1'b0;
      enable      <= 1'b0;
      irq_en      <= 1'b0;
      threshold   <= THR_RST;
    end else begin
      underflow   <= udf_set | (underflow   & ~(stat_wr & fifo_writedata[2]));
      overflow    <= ovf_set | (overflow    & ~(stat_wr & fifo_writedata[3]));
      irq_pending <= irq_set | (irq_pending & ~(stat_wr & fifo_writedata[4]));
      if (ctrl_wr) begin
        enable <= fifo_writedata[0];
        irq_en <= fifo_writedata[1];
      end
      if (thr_wr)
        threshold <= fifo_writedata[DEPTH_LOG2:0];
    end
  end

  always_comb begin
    fifo_readdata = 32'd0;
    case (fifo_address)
      3'd0:    fifo_readdata = 32'(level);
      3'd1:    fifo_readdata = {27'd0, irq_pending, overflow, underflow, full, empty};
      3'd2:    fifo_readdata = {30'd0, irq_en, enable};
      3'd3:    fifo_readdata = 32'(threshold);
      3'd4:    fifo_readdata = 32'(sample_out);
      default: fifo_readdata = 32'd0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_ks_sample_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_ks_sample_fifo: random stimulus checked against a queue-based model.    |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_ks_sample_fifo;

  localparam int DATA_W     = 16;
  localparam int DEPTH_LOG2 = 6;
  localparam int DEPTH      = 64;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [2:0]        fifo_address = 3'd0;
  logic              fifo_chipselect = 1'b0;
  logic              fifo_write = 1'b0;
  logic [31:0]       fifo_writedata = 32'd0;
  logic [31:0]       fifo_readdata;
  logic              fifo_irq;
  logic              sample_tick = 1'b0;
  logic [DATA_W-1:0] sample_out;
  logic              sample_valid;

  ks_sample_fifo #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk             (clk),
    .reset           (reset),
    .fifo_address    (fifo_address),
    .fifo_chipselect (fifo_chipselect),
    .fifo_write      (fifo_write),
    .fifo_writedata  (fifo_writedata),
    .fifo_readdata   (fifo_readdata),
    .fifo_irq        (fifo_irq),
    .sample_tick     (sample_tick),
    .sample_out      (sample_out),
    .sample_valid    (sample_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int q[$];
  bit m_under, m_over, m_irqp, m_en, m_irqen;
  int m_thr    = DEPTH / 2;
  int m_sample = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    return {27'd0, m_irqp, m_over, m_under, q.size() == DEPTH, q.size() == 0};
  endfunction

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    fifo_address    = a;
    fifo_writedata  = d;
    fifo_chipselect = 1'b1;
    fifo_write      = 1'b1;
    @(negedge clk);
    fifo_chipselect = 1'b0;
    fifo_write      = 1'b0;
  endtask

  task automatic check_reg(input string tag, input logic [2:0] a, input logic [31:0] exp);
    @(negedge clk);
    fifo_address    = a;
    fifo_chipselect = 1'b1;
    fifo_write      = 1'b0;
    #1;
    chk(tag, fifo_readdata, exp);
    fifo_chipselect = 1'b0;
  endtask

  task automatic check_all();
    check_reg("level", 3'd0, q.size());
    check_reg("status", 3'd1, m_status());
    check_reg("control", 3'd2, {30'd0, m_irqen, m_en});
    check_reg("threshold", 3'd3, m_thr);
    check_reg("sample_rd", 3'd4, m_sample);
    chk("irq", {31'd0, fifo_irq}, {31'd0, m_irqp & m_irqen});
  endtask

  task automatic push(input logic [31:0] d);
    bus_write(3'd0, d);
    if (q.size() < DEPTH) q.push_back(int'(d & 32'h0000_FFFF));
    else m_over = 1'b1;
  endtask

  task automatic set_ctrl(input logic [31:0] d);
    bus_write(3'd2, d);
    m_en    = d[0];
    m_irqen = d[1];
  endtask

  task automatic w1c(input logic [31:0] d);
    bus_write(3'd1, d);
    if (d[2]) m_under = 1'b0;
    if (d[3]) m_over  = 1'b0;
    if (d[4]) m_irqp  = 1'b0;
  endtask

  task automatic set_thr(input logic [31:0] d);
    bus_write(3'd3, d);
    m_thr = int'(d & 32'h7F);
  endtask

  task automatic flush();
    bus_write(3'd4, $urandom);
    q.delete();
  endtask

  // One tick pulse; output must change exactly 3 edges after the edge that sees it high.
  task automatic tick_op();
    logic ev;
    ev = 1'b0;
    if (m_en) begin
      if (q.size() > 0) begin
        ev = 1'b1;
        m_sample = q.pop_front();
        if (q.size() <= m_thr) m_irqp = 1'b1;
      end else begin
        m_under = 1'b1;
        m_irqp  = 1'b1;
      end
    end
    @(negedge clk);
    sample_tick = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("valid_early", {31'd0, sample_valid}, 32'd0);
    end
    @(negedge clk);
    chk("valid", {31'd0, sample_valid}, {31'd0, ev});
    chk("sample_out", {16'd0, sample_out}, m_sample);
    sample_tick = 1'b0;
    @(negedge clk);
    chk("valid_pulse", {31'd0, sample_valid}, 32'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int exp_front;
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Reset values
    check_reg("rst_status", 3'd1, 32'h0000_0001);
    check_reg("rst_thr", 3'd3, 32'h0000_0020);
    chk("rst_sample", {16'd0, sample_out}, 32'd0);
    chk("rst_irq", {31'd0, fifo_irq}, 32'd0);
    check_all();

    // Basic in-order playback
    push(32'h1111); push(32'h2222); push(32'hABCD_3333);
    set_ctrl(32'h1);
    tick_op(); chk("seq1", {16'd0, sample_out}, 32'h1111);
    tick_op(); chk("seq2", {16'd0, sample_out}, 32'h2222);
    tick_op(); chk("seq3", {16'd0, sample_out}, 32'h3333);
    check_all();

    // Underflow on empty tick with irq enabled
    set_ctrl(32'h3);
    tick_op();
    check_reg("udf_status", 3'd1, 32'h15);
    chk("udf_irq", {31'd0, fifo_irq}, 32'd1);
    chk("udf_hold", {16'd0, sample_out}, 32'h3333);
    w1c(32'h1C);
    check_reg("clr_status", 3'd1, 32'h01);
    chk("clr_irq", {31'd0, fifo_irq}, 32'd0);

    // Fill past full, then drain
    set_ctrl(32'h0);
    for (int i = 0; i <= DEPTH; i++) push(i);
    check_reg("full_level", 3'd0, 32'd64);
    check_reg("full_status", 3'd1, 32'h0A);
    set_ctrl(32'h1);
    for (int i = 0; i < DEPTH; i++) tick_op();
    chk("drain_last", {16'd0, sample_out}, 32'd63);
    check_all();

    // Low-water interrupt on the second pop
    flush(); w1c(32'h1C);
    set_thr(32'd2);
    for (int i = 0; i < 4; i++) push($urandom);
    set_ctrl(32'h3);
    tick_op(); chk("thr_pop1_irq", {31'd0, fifo_irq}, 32'd0);
    tick_op(); chk("thr_pop2_irq", {31'd0, fifo_irq}, 32'd1);
    check_all();

    // Randomised mixed traffic
    for (int it = 0; it < 250; it++) begin
      case ($urandom_range(0, 11))
        0, 1, 2, 3, 4: push($urandom);
        5, 6, 7:       tick_op();
        8:             set_ctrl($urandom);
        9:             w1c($urandom);
        10:            if ($urandom_range(0, 1) == 0) set_thr($urandom); else flush();
        default: begin
          d = 32'($urandom_range(5, 7));
          bus_write(d[2:0], $urandom);
          check_reg("unmapped", d[2:0], 32'd0);
        end
      endcase
      check_reg("rnd_level", 3'd0, q.size());
      check_reg("rnd_status", 3'd1, m_status());
      chk("rnd_irq", {31'd0, fifo_irq}, {31'd0, m_irqp & m_irqen});
    end
    check_all();

    // Full FIFO: push lands on the same edge as the pop
    flush(); w1c(32'h1C); set_thr(32'd32); set_ctrl(32'h1);
    for (int i = 0; i < DEPTH; i++) push($urandom);
    exp_front = q[0];
    d = $urandom;
    @(negedge clk);
    sample_tick = 1'b1;
    repeat (3) @(negedge clk);
    fifo_address    = 3'd0;
    fifo_writedata  = d;
    fifo_chipselect = 1'b1;
    fifo_write      = 1'b1;
    @(negedge clk);
    fifo_chipselect = 1'b0;
    fifo_write      = 1'b0;
    chk("simul_valid", {31'd0, sample_valid}, 32'd1);
    chk("simul_out", {16'd0, sample_out}, exp_front);
    sample_tick = 1'b0;
    m_sample = q.pop_front();
    q.push_back(int'(d & 32'h0000_FFFF));
    if (q.size() <= m_thr) m_irqp = 1'b1;
    repeat (3) @(negedge clk);
    check_reg("simul_level", 3'd0, 32'd64);
    check_all();

    // Reset mid-stream with a tick in flight
    @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    fifo_address = 3'd0;
    #1;
    chk("arst_level", fifo_readdata, 32'd0);
    chk("arst_sample", {16'd0, sample_out}, 32'd0);
    chk("arst_irq", {31'd0, fifo_irq}, 32'd0);
    sample_tick = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_valid", {31'd0, sample_valid}, 32'd0);
    end
    q.delete();
    m_under = 0; m_over = 0; m_irqp = 0; m_en = 0; m_irqen = 0;
    m_thr = DEPTH / 2; m_sample = 0;
    check_all();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
